// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-16 bit demultiplexer/deserializer.
package demux_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned SEL_WIDTH_DEF  = 4;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_SEQ  = 1'b1;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/demux_if.sv
// Beat input and word output bundle of the demultiplexer; slave is the DUT side.
interface demux_if
    import demux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned SEL_WIDTH  = SEL_WIDTH_DEF
);

    logic                  clear;
    logic                  mode;
    logic                  bit_in;
    logic [SEL_WIDTH-1:0]  sel_in;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_hit;

    modport master (
        output clear, mode, bit_in, sel_in, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_hit
    );

    modport slave (
        input  clear, mode, bit_in, sel_in, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_hit
    );

endinterface

// File: rtl/demux_decode4x16.sv
// Combinational select-to-one-hot decoder with enable; all zero when disabled.
module demux_decode4x16
    import demux_pkg::*;
#(
    parameter int unsigned SEL_WIDTH = SEL_WIDTH_DEF
) (
    input  logic [SEL_WIDTH-1:0]        sel,
    input  logic                        en,
    output logic [(2**SEL_WIDTH)-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_1x16.sv
// Registered 1-to-16 demultiplexer: steers single-bit beats into a word by select
// or position counter, and hands completed words out through a double-buffered slot.
module demux_1x16
    import demux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned SEL_WIDTH  = SEL_WIDTH_DEF
) (
    input  logic    clk,
    input  logic    rst_n,
    demux_if.slave  bus
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned SW = SEL_WIDTH;

    state_e          state_q, state_d;
    logic [DW-1:0]   shadow_q, shadow_d;
    logic [DW-1:0]   mask_q, mask_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_hit_q;

    logic            in_ready_c;
    logic            frame_mode;
    logic [SW-1:0]   pos;
    logic            accept;
    logic            take;
    logic            complete;
    logic [DW-1:0]   hit;
    logic [DW-1:0]   shadow_wr;
    logic [DW-1:0]   mask_wr;

    // Mode is sampled live on the first beat of a frame, latched afterwards.
    assign in_ready_c = (state_q == FILL) && !bus.clear;
    assign frame_mode = (mask_q == '0) ? bus.mode : mode_q;
    assign pos        = (frame_mode == MODE_SEQ) ? cnt_q : bus.sel_in;
    assign accept     = bus.in_valid && in_ready_c;
    assign take       = out_valid_q && bus.out_ready;

    demux_decode4x16 #(
        .SEL_WIDTH (SW)
    ) u_decode (
        .sel    (pos),
        .en     (accept),
        .onehot (hit)
    );

    assign shadow_wr = (shadow_q & ~hit) | (hit & {DW{bus.bit_in}});
    assign mask_wr   = mask_q | hit;
    assign complete  = accept && (&mask_wr);

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !take;

        case (state_q)
            FILL: begin
                if (bus.clear) begin
                    mask_d = '0;
                    cnt_d  = '0;
                    mode_d = MODE_ADDR;
                end else if (accept) begin
                    shadow_d = shadow_wr;
                    mask_d   = mask_wr;
                    mode_d   = frame_mode;
                    cnt_d    = (frame_mode == MODE_SEQ) ? cnt_q + SW'(1) : '0;
                    if (complete) begin
                        if (!out_valid_q || take) begin
                            out_data_d  = shadow_wr;
                            out_valid_d = 1'b1;
                            mask_d      = '0;
                            cnt_d       = '0;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                // The completed word waits in the shadow until the slot is taken.
                if (take) begin
                    out_data_d  = shadow_q;
                    out_valid_d = 1'b1;
                    mask_d      = '0;
                    cnt_d       = '0;
                    state_d     = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            shadow_q    <= '0;
            mask_q      <= '0;
            cnt_q       <= '0;
            mode_q      <= MODE_ADDR;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_hit_q   <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_hit_q   <= hit;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_hit   = out_hit_q;

endmodule

// File: tb/tb_demux_1x16.sv
// Directed self-checking bench for demux_1x16: inputs change and outputs are sampled on the falling edge.
module tb_demux_1x16;
    import demux_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    demux_if u_if ();

    demux_1x16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    int ready_lows  = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One beat offered for exactly one rising edge; records any cycle without in_ready.
    task automatic beat(input logic b, input logic [3:0] s, input logic m);
        u_if.in_valid = 1'b1;
        u_if.bit_in   = b;
        u_if.sel_in   = s;
        u_if.mode     = m;
        #1;
        if (!u_if.in_ready) ready_lows++;
        @(negedge clk);
        u_if.in_valid = 1'b0;
    endtask

    // Sequential frame, LSB first; sel_in is varied to show it is ignored.
    task automatic send_seq(input logic [15:0] w);
        for (int i = 0; i < 16; i++) begin
            beat(w[i], 4'(15 - i), MODE_SEQ);
        end
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst out_valid", 16'(u_if.out_valid), 16'h0000);
        chk("async_rst out_data",  u_if.out_data,       16'h0000);
        chk("async_rst out_hit",   u_if.out_hit,        16'h0000);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] pat;

        rst_n          = 1'b0;
        u_if.clear     = 1'b0;
        u_if.mode      = MODE_ADDR;
        u_if.bit_in    = 1'b0;
        u_if.sel_in    = 4'h0;
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("reset out_data",  u_if.out_data,        16'h0000);
        chk("reset out_valid", 16'(u_if.out_valid),  16'h0000);
        chk("reset out_hit",   u_if.out_hit,         16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset in_ready",  16'(u_if.in_ready),   16'h0001);

        // Sequential 0xA5C3 with the consumer always ready.
        u_if.out_ready = 1'b1;
        ready_lows     = 0;
        pat            = 16'hA5C3;
        for (int i = 0; i < 16; i++) begin
            beat(pat[i], 4'(15 - i), MODE_SEQ);
            if (i == 14) chk("seq early out_valid", 16'(u_if.out_valid), 16'h0000);
        end
        chk("seq out_valid",   16'(u_if.out_valid), 16'h0001);
        chk("seq out_data",    u_if.out_data,       16'hA5C3);
        chk("seq no bubbles",  16'(ready_lows),     16'h0000);
        @(negedge clk);
        chk("seq taken",       16'(u_if.out_valid), 16'h0000);

        // Addressed descending, with an early write of position 0.
        for (int s = 15; s >= 8; s--) beat(s[0], 4'(s), MODE_ADDR);
        beat(1'b1, 4'h0, MODE_ADDR);
        chk("addr hit sel0", u_if.out_hit, 16'h0001);
        for (int s = 7; s >= 2; s--) beat(s[0], 4'(s), MODE_ADDR);
        chk("addr not done", 16'(u_if.out_valid), 16'h0000);
        beat(1'b1, 4'h1, MODE_ADDR);
        chk("addr out_valid", 16'(u_if.out_valid), 16'h0001);
        chk("addr out_data",  u_if.out_data,       16'hAAAB);
        chk("addr hit sel1",  u_if.out_hit,        16'h0002);
        @(negedge clk);

        // Back-pressure: second frame parks in HOLD.
        u_if.out_ready = 1'b0;
        send_seq(16'h1234);
        chk("bp first valid", 16'(u_if.out_valid), 16'h0001);
        chk("bp first data",  u_if.out_data,       16'h1234);
        chk("bp in_ready",    16'(u_if.in_ready),  16'h0001);
        ready_lows = 0;
        send_seq(16'hFFFF);
        chk("bp fill ready",  16'(ready_lows),     16'h0000);
        chk("bp hold stall",  16'(u_if.in_ready),  16'h0000);
        chk("bp slot kept",   u_if.out_data,       16'h1234);
        u_if.clear = 1'b1;
        @(negedge clk);
        u_if.clear = 1'b0;
        chk("bp stall after clear", 16'(u_if.in_ready), 16'h0000);
        u_if.out_ready = 1'b1;
        @(negedge clk);
        chk("bp ready back",  16'(u_if.in_ready),  16'h0001);
        chk("bp second valid",16'(u_if.out_valid), 16'h0001);
        chk("bp second data", u_if.out_data,       16'hFFFF);
        @(negedge clk);
        chk("bp drained",     16'(u_if.out_valid), 16'h0000);

        // clear discards a partial frame and blocks the concurrent beat.
        for (int i = 0; i < 7; i++) beat(1'b1, 4'h3, MODE_SEQ);
        u_if.clear    = 1'b1;
        u_if.in_valid = 1'b1;
        u_if.bit_in   = 1'b1;
        #1;
        chk("clear in_ready", 16'(u_if.in_ready), 16'h0000);
        @(negedge clk);
        u_if.clear    = 1'b0;
        u_if.in_valid = 1'b0;
        chk("clear no hit",   u_if.out_hit, 16'h0000);
        send_seq(16'h0F0F);
        chk("clear out_valid", 16'(u_if.out_valid), 16'h0001);
        chk("clear out_data",  u_if.out_data,       16'h0F0F);
        @(negedge clk);

        // Mode dropped to addressed mid-frame: frame stays sequential.
        pat = 16'h3C96;
        for (int i = 0; i < 16; i++) begin
            beat(pat[i], 4'h7, (i < 3) ? MODE_SEQ : MODE_ADDR);
            chk($sformatf("walk hit%0d", i), u_if.out_hit, 16'(16'h0001 << i));
        end
        chk("walk out_valid", 16'(u_if.out_valid), 16'h0001);
        chk("walk out_data",  u_if.out_data,       16'h3C96);
        @(negedge clk);
        chk("walk idle hit",  u_if.out_hit,        16'h0000);

        // Asynchronous reset in HOLD, then mid-frame.
        u_if.out_ready = 1'b0;
        send_seq(16'h1111);
        send_seq(16'h2222);
        chk("hold before rst", 16'(u_if.in_ready), 16'h0000);
        pulse_reset();
        chk("rst in_ready", 16'(u_if.in_ready), 16'h0001);
        u_if.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) beat(1'b1, 4'h0, MODE_SEQ);
        pulse_reset();
        pat = 16'hBEEF;
        for (int i = 0; i < 15; i++) beat(pat[i], 4'h9, MODE_SEQ);
        chk("post rst no old word", 16'(u_if.out_valid), 16'h0000);
        beat(pat[15], 4'h9, MODE_SEQ);
        chk("post rst out_valid", 16'(u_if.out_valid), 16'h0001);
        chk("post rst out_data",  u_if.out_data,       16'hBEEF);
        @(negedge clk);
        chk("post rst drained",   16'(u_if.out_valid), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
